mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- MEM stage of the 5-stage RV32 pipeline.
- Takes EXE/MEM pipeline signals and performs a word load or store on an internal synchronous data memory.
- Registers the load data, ALU result and writeback control into the MEM/WB pipeline register for the WB stage.

Parameters:
- DATA_WIDTH, 32, width of data words, addresses and ALU result.
- MEM_DEPTH, 256, number of DATA_WIDTH words in the data memory (power of two).
- REG_ADDR_WIDTH, 5, width of register-file index.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- mem_read_exe_mem  input  1  load request.
- mem_write_exe_mem  input  1  store request.
- mem_to_reg_exe_mem  input  1  WB select: 1 = memory data, 0 = ALU result.
- alu_out_exe_mem  input  32  byte address for load/store; also the ALU result forwarded to WB.
- w_data_exe_mem  input  32  store data.
- write_reg_exe_mem  input  5  destination register index.
- r_data_mem_wb  output  32  registered load data.
- reg_out_mem_wb  output  32  registered ALU result.
- mem_to_reg_mem_wb  output  1  registered mem_to_reg.
- write_reg_mem_wb  output  5  registered destination index.

Behaviour:
- All state updates on the rising edge of clk.
- Reset (rst_n=0 at a clock edge):
  - All four outputs clear to 0.
  - No memory write occurs that cycle, even if mem_write_exe_mem=1.
  - Memory contents are not cleared.
- Memory initial contents: all words are 0 at time zero. A never-written word reads 0.
- Addressing:
  - Word index = alu_out_exe_mem[log2(MEM_DEPTH)+1 : 2].
  - Bits [1:0] are ignored (word-aligned access only).
  - Bits above the index are ignored, so the address wraps modulo MEM_DEPTH*4 bytes.
- Store: if mem_write_exe_mem=1 and rst_n=1, mem[index] <= w_data_exe_mem at the edge. The stored value is visible to a load in the next cycle.
- Load:
  - If mem_read_exe_mem=1, r_data_mem_wb <= mem[index] at the same edge.
  - Latency: one cycle from inputs presented to valid r_data_mem_wb.
  - If mem_read_exe_mem=0, r_data_mem_wb holds its previous value.
- Simultaneous read and write:
  - Different addresses: both are performed.
  - Same address: read-first, so r_data_mem_wb gets the old word and the memory gets the new word.
- Pass-through (registered every non-reset edge, one-cycle latency):
  - reg_out_mem_wb <= alu_out_exe_mem
  - mem_to_reg_mem_wb <= mem_to_reg_exe_mem
  - write_reg_mem_wb <= write_reg_exe_mem
- No stall or flush inputs; the stage advances every cycle. No handshakes.
- No byte or halfword accesses, no misalignment exceptions.

Decomposition:
- Shared package rv32_pkg holds:
  - XLEN = 32
  - REG_ADDR_WIDTH = 5
  - DMEM_DEPTH default
  - word type logic [XLEN-1:0]
  - register-index type
- Sub-module data_mem: single-port synchronous RAM with write enable, read enable and word index, read-first, zero-initialised, registered read output.
- mem_access holds the address slicing, the MEM/WB pass-through registers and the reset gating.

Test Plan:
1. Store then load: cycle 0 write=1, addr 0x10, data 0xDEADBEEF; cycle 1 read=1, mem_to_reg=1, addr 0x10 → after the cycle-1 edge, r_data_mem_wb=0xDEADBEEF and mem_to_reg_mem_wb=1.
2. Unwritten location: read addr 0x20 with no prior store → r_data_mem_wb=0x00000000.
3. Pass-through: alu_out=0x12345678, write_reg=5'd7, mem_to_reg=0, no read/write → next edge reg_out_mem_wb=0x12345678, write_reg_mem_wb=7, mem_to_reg_mem_wb=0, r_data_mem_wb unchanged.
4. Same-address read+write: mem[0x40]=0x11111111; write 0x22222222 and read at 0x40 in the same cycle → r_data_mem_wb=0x11111111; next-cycle read returns 0x22222222.
5. Wrap/alignment: store 0xA5A5A5A5 at 0x13 → read at 0x10 returns 0xA5A5A5A5; read at 0x10 + MEM_DEPTH*4 returns 0xA5A5A5A5.
6. Reset: drive all outputs nonzero, then rst_n=0 with write=1, addr 0x30, data 0xFFFFFFFF for one edge → all outputs 0; after release, read 0x30 returns 0; mem[0x10] still returns its earlier value.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline types and widths.
// Imported by every pipeline stage.
package rv32_pkg;

    localparam int XLEN           = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int DMEM_DEPTH     = 256;

    typedef logic [XLEN-1:0]           word_t;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/data_mem.sv
// Single-port word RAM, read-first, registered read data.
// Contents power up as zero and are never cleared.
module data_mem
    import rv32_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int MEM_DEPTH  = DMEM_DEPTH,
    parameter int IDX_WIDTH  = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_clr,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [IDX_WIDTH-1:0]  i_idx,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    // Read samples the pre-write word, giving read-first semantics.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_access.sv
// MEM stage: word load/store on the data memory and
// the MEM/WB pipeline register.
module mem_access
    import rv32_pkg::*;
#(
    parameter int DATA_WIDTH     = XLEN,
    parameter int MEM_DEPTH      = DMEM_DEPTH,
    parameter int REG_ADDR_WIDTH = rv32_pkg::REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mem_read_exe_mem,
    input  logic                      mem_write_exe_mem,
    input  logic                      mem_to_reg_exe_mem,
    input  logic [DATA_WIDTH-1:0]     alu_out_exe_mem,
    input  logic [DATA_WIDTH-1:0]     w_data_exe_mem,
    input  logic [REG_ADDR_WIDTH-1:0] write_reg_exe_mem,
    output logic [DATA_WIDTH-1:0]     r_data_mem_wb,
    output logic [DATA_WIDTH-1:0]     reg_out_mem_wb,
    output logic                      mem_to_reg_mem_wb,
    output logic [REG_ADDR_WIDTH-1:0] write_reg_mem_wb
);

    localparam int IDX_WIDTH = $clog2(MEM_DEPTH);

    logic [IDX_WIDTH-1:0]      w_idx;
    logic                      w_we;
    logic                      w_clr;
    logic [DATA_WIDTH-1:0]     r_reg_out;
    logic                      r_mem_to_reg;
    logic [REG_ADDR_WIDTH-1:0] r_write_reg;

    // Byte offset dropped; upper bits ignored so addresses wrap.
    assign w_idx = alu_out_exe_mem[IDX_WIDTH+1:2];
    assign w_we  = mem_write_exe_mem & rst_n;
    assign w_clr = ~rst_n;

    data_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_dmem (
        .clk     (clk),
        .i_clr   (w_clr),
        .i_we    (w_we),
        .i_re    (mem_read_exe_mem),
        .i_idx   (w_idx),
        .i_wdata (w_data_exe_mem),
        .o_rdata (r_data_mem_wb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_reg_out    <= '0;
            r_mem_to_reg <= 1'b0;
            r_write_reg  <= '0;
        end else begin
            r_reg_out    <= alu_out_exe_mem;
            r_mem_to_reg <= mem_to_reg_exe_mem;
            r_write_reg  <= write_reg_exe_mem;
        end
    end

    assign reg_out_mem_wb    = r_reg_out;
    assign mem_to_reg_mem_wb = r_mem_to_reg;
    assign write_reg_mem_wb  = r_write_reg;

endmodule

// File: tb/tb_mem_access.sv
// Randomised check of mem_access against a word-array
// reference model, plus directed corner cases.
module tb_mem_access;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd, wr, m2r;
    logic [31:0] addr, wdata;
    logic [4:0]  wreg;
    logic [31:0] r_data, reg_out;
    logic        m2r_o;
    logic [4:0]  wreg_o;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mdl [DEPTH];
    logic [31:0] e_rd, e_ro;
    logic        e_m2r;
    logic [4:0]  e_wr;

    always #5 clk = ~clk;

    mem_access dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .mem_read_exe_mem   (rd),
        .mem_write_exe_mem  (wr),
        .mem_to_reg_exe_mem (m2r),
        .alu_out_exe_mem    (addr),
        .w_data_exe_mem     (wdata),
        .write_reg_exe_mem  (wreg),
        .r_data_mem_wb      (r_data),
        .reg_out_mem_wb     (reg_out),
        .mem_to_reg_mem_wb  (m2r_o),
        .write_reg_mem_wb   (wreg_o)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h",
                     tag, got, exp);
        end
    endtask

    // One pipeline cycle: drive, clock, update model, compare.
    task automatic step(input logic        i_rst,
                        input logic        i_rd,
                        input logic        i_wr,
                        input logic        i_m2r,
                        input logic [31:0] i_addr,
                        input logic [31:0] i_wdata,
                        input logic [4:0]  i_wreg);
        int idx;
        @(negedge clk);
        rst_n = i_rst;
        rd    = i_rd;
        wr    = i_wr;
        m2r   = i_m2r;
        addr  = i_addr;
        wdata = i_wdata;
        wreg  = i_wreg;
        @(posedge clk);
        idx = int'((i_addr / 4) % DEPTH);
        if (!i_rst) begin
            e_rd  = '0;
            e_ro  = '0;
            e_m2r = 1'b0;
            e_wr  = '0;
        end else begin
            if (i_rd) e_rd = mdl[idx];
            if (i_wr) mdl[idx] = i_wdata;
            e_ro  = i_addr;
            e_m2r = i_m2r;
            e_wr  = i_wreg;
        end
        #1;
        check("r_data", r_data, e_rd);
        check("reg_out", reg_out, e_ro);
        check("mem_to_reg", {31'd0, m2r_o}, {31'd0, e_m2r});
        check("write_reg", {27'd0, wreg_o}, {27'd0, e_wr});
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        e_rd = '0; e_ro = '0; e_m2r = 1'b0; e_wr = '0;
        rst_n = 1'b0; rd = 1'b0; wr = 1'b0; m2r = 1'b0;
        addr = '0; wdata = '0; wreg = '0;

        step(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        check("reset_rdata", r_data, 32'h0);

        // Store then load
        step(1, 0, 1, 0, 32'h10, 32'hDEADBEEF, 5'd1);
        step(1, 1, 0, 1, 32'h10, 32'h0, 5'd2);
        check("t1_load", r_data, 32'hDEADBEEF);
        check("t1_m2r", {31'd0, m2r_o}, 32'd1);

        // Unwritten location
        step(1, 1, 0, 1, 32'h20, 32'h0, 5'd3);
        check("t2_zero", r_data, 32'h0);

        // Pass-through, r_data holds
        step(1, 1, 0, 1, 32'h10, 32'h0, 5'd3);
        step(1, 0, 0, 0, 32'h12345678, 32'h0, 5'd7);
        check("t3_ro", reg_out, 32'h12345678);
        check("t3_hold", r_data, 32'hDEADBEEF);

        // Same-address read+write is read-first
        step(1, 0, 1, 0, 32'h40, 32'h11111111, 5'd0);
        step(1, 1, 1, 1, 32'h40, 32'h22222222, 5'd4);
        check("t4_old", r_data, 32'h11111111);
        step(1, 1, 0, 1, 32'h40, 32'h0, 5'd4);
        check("t4_new", r_data, 32'h22222222);

        // Alignment and wrap
        step(1, 0, 1, 0, 32'h13, 32'hA5A5A5A5, 5'd0);
        step(1, 1, 0, 1, 32'h10, 32'h0, 5'd5);
        check("t5_align", r_data, 32'hA5A5A5A5);
        step(1, 1, 0, 1, 32'h10 + DEPTH * 4, 32'h0, 5'd5);
        check("t5_wrap", r_data, 32'hA5A5A5A5);

        // Reset blocks the write and clears outputs
        step(1, 1, 0, 1, 32'hFFFF0010, 32'h0, 5'd31);
        step(0, 0, 1, 1, 32'h30, 32'hFFFFFFFF, 5'd9);
        check("t6_rst_rd", r_data, 32'h0);
        check("t6_rst_ro", reg_out, 32'h0);
        step(1, 1, 0, 0, 32'h30, 32'h0, 5'd0);
        check("t6_nowr", r_data, 32'h0);
        step(1, 1, 0, 0, 32'h10, 32'h0, 5'd0);
        check("t6_kept", r_data, 32'hA5A5A5A5);

        // Random traffic over a small window to force aliasing
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = $urandom_range(0, 63);
            if ($urandom_range(0, 3) == 0)
                a = a + DEPTH * 4 * $urandom_range(1, 7);
            step(($urandom_range(0, 19) != 0),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 a, $urandom, 5'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
